// File: rtl/serial_mem_port.sv
// Bit-serial slave port in front of a single-port synchronous RAM.
// Supports cs-framed reads and writes with burst auto-increment, a registered output and abort detection.
module serial_mem_port #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int TURN   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       din,
  output logic       dout,
  output logic       dout_en,
  output logic       busy,
  output logic       frame_err,
  output logic [2:0] dbg_state_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(ADDR_W + DATA_W + TURN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_TURN  = 3'd2,
    S_WDATA = 3'd3,
    S_RDATA = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic                wr_q, wr_d;
  logic                dout_q, dout_d;
  logic                dout_en_q, dout_en_d;
  logic                ferr_q, ferr_d;
  logic                we_d;
  logic                mem_we;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign wdata = {sh_q[DATA_W-2:0], din};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    sh_d      = sh_q;
    wr_d      = wr_q;
    dout_d    = 1'b0;
    dout_en_d = 1'b0;
    ferr_d    = 1'b0;
    we_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cs) begin
          wr_d    = din;
          cnt_d   = '0;
          state_d = S_ADDR;
        end
      end
      default: begin
        if (!cs) begin
          // A frame may only end cleanly on a word boundary or while reading.
          state_d = S_IDLE;
          cnt_d   = '0;
          ferr_d  = (state_q == S_ADDR) || ((state_q == S_WDATA) && (cnt_q != '0));
        end else begin
          case (state_q)
            S_ADDR: begin
              addr_d = {addr_q[ADDR_W-2:0], din};
              if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                cnt_d   = '0;
                state_d = wr_q ? S_WDATA : S_TURN;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            S_TURN: begin
              if (cnt_q == CNT_W'(TURN - 1)) begin
                sh_d      = rdata_q << 1;
                dout_d    = rdata_q[DATA_W-1];
                dout_en_d = 1'b1;
                addr_d    = addr_q + 1'b1;
                cnt_d     = '0;
                state_d   = S_RDATA;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            S_WDATA: begin
              sh_d = wdata;
              if (cnt_q == CNT_W'(DATA_W - 1)) begin
                we_d   = 1'b1;
                addr_d = addr_q + 1'b1;
                cnt_d  = '0;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            S_RDATA: begin
              dout_en_d = 1'b1;
              // rdata_q already holds the prefetched next word when the LSB is on dout.
              if (cnt_q == CNT_W'(DATA_W - 1)) begin
                sh_d   = rdata_q << 1;
                dout_d = rdata_q[DATA_W-1];
                addr_d = addr_q + 1'b1;
                cnt_d  = '0;
              end else begin
                sh_d   = sh_q << 1;
                dout_d = sh_q[DATA_W-1];
                cnt_d  = cnt_q + 1'b1;
              end
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      sh_q      <= '0;
      wr_q      <= 1'b0;
      dout_q    <= 1'b0;
      dout_en_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      sh_q      <= sh_d;
      wr_q      <= wr_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
      ferr_q    <= ferr_d;
    end
  end

  // Single port: the read of addr_q runs every cycle, the write shares the same address.
  assign mem_we = we_d && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata;
    end
    rdata_q <= mem[addr_q];
  end

  assign dout        = dout_q;
  assign dout_en     = dout_en_q;
  assign frame_err   = ferr_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_mem_port.sv
// Self-checking bench for serial_mem_port: directed frames, aborts, resets and random bursts
// against a word-level memory model with an expected-word queue.
module tb_serial_mem_port;

  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int TN    = 2;
  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs;
  logic       din;
  logic       dout;
  logic       dout_en;
  logic       busy;
  logic       frame_err;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] wr_q  [$];

  serial_mem_port #(.ADDR_W(AW), .DATA_W(DW), .TURN(TN)) dut (
    .clk         (clk),
    .rst         (rst),
    .cs          (cs),
    .din         (din),
    .dout        (dout),
    .dout_en     (dout_en),
    .busy        (busy),
    .frame_err   (frame_err),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    din = b;
    tick();
  endtask

  task automatic send_hdr(input logic wr, input int unsigned a);
    cs = 1'b1;
    send_bit(wr);
    chk("busy_rise", {31'd0, busy}, 32'd1);
    for (int i = AW - 1; i >= 0; i--) send_bit(a[i]);
  endtask

  task automatic end_frame(input string tag, input logic exp_err);
    cs  = 1'b0;
    din = 1'($urandom_range(0, 1));
    tick();
    chk({tag, "_err"},  {31'd0, frame_err}, {31'd0, exp_err});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_den"},  {31'd0, dout_en}, 32'd0);
    chk({tag, "_dout"}, {31'd0, dout}, 32'd0);
    tick();
    chk({tag, "_errw"}, {31'd0, frame_err}, 32'd0);
  endtask

  // Writes every word queued in wr_q as one burst starting at a.
  task automatic write_frame(input int unsigned a);
    logic [DW-1:0] w;
    int k;
    send_hdr(1'b1, a);
    k = 0;
    while (wr_q.size() > 0) begin
      w = wr_q.pop_front();
      for (int i = DW - 1; i >= 0; i--) send_bit(w[i]);
      mem_m[(a + k) % DEPTH] = w;
      k++;
    end
    end_frame("wr", 1'b0);
  endtask

  // Reads n words from a; each is compared with the head of exp_q.
  task automatic read_frame(input int unsigned a, input int n);
    logic [DW-1:0] obs;
    send_hdr(1'b0, a);
    for (int t = 0; t < TN; t++) begin
      din = 1'($urandom_range(0, 1));
      tick();
      if (t < TN - 1) chk("turn_den", {31'd0, dout_en}, 32'd0);
    end
    for (int k = 0; k < n; k++) begin
      obs = '0;
      for (int i = 0; i < DW; i++) begin
        chk("rd_den", {31'd0, dout_en}, 32'd1);
        obs = {obs[DW-2:0], dout};
        if (i < DW - 1 || k < n - 1) begin
          din = 1'($urandom_range(0, 1));
          tick();
        end
      end
      if (exp_q.size() == 0) chk("rd_noexp", 32'd1, {31'd0, busy});
      else chk("rd_word", {16'd0, obs}, {16'd0, exp_q.pop_front()});
    end
    end_frame("rd", 1'b0);
  endtask

  task automatic abort_write(input int unsigned a, input int nbits);
    send_hdr(1'b1, a);
    for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)));
    end_frame("wabort", 1'b1);
  endtask

  initial begin
    logic [DW-1:0] w;
    int unsigned   a;
    int            n;

    // Reset with cs high and din toggling.
    rst = 1'b1; cs = 1'b1; din = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din = ~din;
      tick();
      chk("rst_dout", {31'd0, dout}, 32'd0);
      chk("rst_den",  {31'd0, dout_en}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err",  {31'd0, frame_err}, 32'd0);
    end
    rst = 1'b0; cs = 1'b0;
    tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_den",  {31'd0, dout_en}, 32'd0);
    chk("post_rst_err",  {31'd0, frame_err}, 32'd0);

    // Fill the whole memory with one wrapping burst so every later read is defined.
    a = $urandom_range(0, DEPTH - 1);
    for (int i = 0; i < DEPTH; i++) wr_q.push_back(DW'($urandom));
    write_frame(a);

    // Single write / read.
    wr_q.push_back(16'hA5C3);
    write_frame(3);
    exp_q.push_back(16'hA5C3);
    read_frame(3, 1);

    // Burst with wrap across the top of memory.
    wr_q.push_back(16'h1111); wr_q.push_back(16'h2222); wr_q.push_back(16'h3333);
    write_frame(30);
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222); exp_q.push_back(16'h3333);
    read_frame(30, 3);
    exp_q.push_back(16'h3333);
    read_frame(0, 1);

    // Write abort after 9 data bits leaves the old word.
    wr_q.push_back(16'hBEEF);
    write_frame(4);
    abort_write(4, 9);
    exp_q.push_back(16'hBEEF);
    read_frame(4, 1);

    // Address abort after 2 address bits.
    cs = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    end_frame("aabort", 1'b1);
    wr_q.push_back(16'h0F0F);
    write_frame(1);
    exp_q.push_back(16'h0F0F);
    read_frame(1, 1);

    // Reset while bit 6 of a read word is on dout.
    w = 16'hA5C3;
    send_hdr(1'b0, 3);
    for (int t = 0; t < TN; t++) send_bit(1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("mid_bit", {31'd0, dout}, {31'd0, w[DW-1-i]});
      send_bit(1'b1);
    end
    chk("mid_bit6", {31'd0, dout}, {31'd0, w[DW-7]});
    rst = 1'b1;
    tick();
    chk("mid_rst_den",  {31'd0, dout_en}, 32'd0);
    chk("mid_rst_dout", {31'd0, dout}, 32'd0);
    chk("mid_rst_err",  {31'd0, frame_err}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; cs = 1'b0;
    tick();
    chk("mid_rst_err2", {31'd0, frame_err}, 32'd0);
    exp_q.push_back(16'hA5C3);
    read_frame(3, 1);

    // Random frames against the memory model.
    for (int f = 0; f < 24; f++) begin
      a = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 3);
      case ($urandom_range(0, 4))
        0, 1: begin
          for (int k = 0; k < n; k++) wr_q.push_back(DW'($urandom));
          write_frame(a);
        end
        2: abort_write(a, $urandom_range(1, DW - 1));
        default: begin
          for (int k = 0; k < n; k++) exp_q.push_back(mem_m[(a + k) % DEPTH]);
          read_frame(a, n);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
